// File: rtl/alarm_responder.sv
// alarm_responder: consumer end of the security-FSM status interface.
// Drives siren/strobe/escalation annunciators from the alarm flag and the
// security state, checks keypad disarm codes, and raises disarm_req so the
// security FSM can fall back to OFF. Repeated wrong codes force a timed LOCKOUT.
// Build option: define ALARM_RESPONDER_AUDIT_EN to build the saturating
// wrong-code audit counter on bad_code_count (tied to 0 otherwise).
module alarm_responder #(
  parameter int unsigned       CODE_W      = 4,
  parameter logic [CODE_W-1:0] DISARM_CODE = CODE_W'(4'hA),
  parameter int unsigned       ESC_CYCLES  = 16,
  parameter int unsigned       SIREN_DIV   = 4,
  parameter int unsigned       MAX_TRIES   = 3,
  parameter int unsigned       LOCK_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alarm_in,
  input  logic [1:0]        state_in,
  input  logic [CODE_W-1:0] code_in,
  input  logic              code_valid,
  output logic              siren,
  output logic              strobe,
  output logic              escalate,
  output logic              disarm_req,
  output logic              lockout,
  output logic [2:0]        resp_state,
  output logic [7:0]        bad_code_count
);

  localparam int unsigned ESC_W  = $clog2(ESC_CYCLES);
  localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES);
  localparam int unsigned DIV_W  = $clog2(SIREN_DIV + 1);
  localparam int unsigned TRY_W  = $clog2(MAX_TRIES + 1);

  localparam logic [ESC_W-1:0]  ESC_LAST  = ESC_W'(ESC_CYCLES - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SIREN_DIV - 1);
  localparam logic [TRY_W-1:0]  TRY_LAST  = TRY_W'(MAX_TRIES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WARN      = 3'd1,
    S_SOUNDING  = 3'd2,
    S_ESCALATED = 3'd3,
    S_DISARM    = 3'd4,
    S_LOCKOUT   = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [ESC_W-1:0]    esc_q, esc_d;
  logic [LOCK_W-1:0]   lock_q, lock_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                phase_q, phase_d;
  logic [TRY_W-1:0]    tries_q, tries_d;

  logic codeOk;
  logic codeBad;
  logic checking;

  assign codeOk   = code_valid && (code_in == DISARM_CODE);
  assign codeBad  = code_valid && (code_in != DISARM_CODE);
  assign checking = (state_q == S_WARN) || (state_q == S_SOUNDING) ||
                    (state_q == S_ESCALATED);

  // Next-state and counter logic; lockout overrides every other transition.
  always_comb begin
    state_d = state_q;
    esc_d   = esc_q;
    lock_d  = lock_q;
    div_d   = div_q;
    phase_d = phase_q;
    tries_d = tries_q;

    case (state_q)
      S_IDLE: begin
        if (alarm_in)                state_d = S_SOUNDING;
        else if (state_in == 2'b10)  state_d = S_WARN;
      end
      S_WARN: begin
        if (alarm_in)                state_d = S_SOUNDING;
        else if (state_in[1] == 1'b0) state_d = S_IDLE;
        else if (codeOk)             state_d = S_DISARM;
      end
      S_SOUNDING: begin
        esc_d = esc_q + 1'b1;
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          phase_d = ~phase_q;
        end else begin
          div_d = div_q + 1'b1;
        end
        if (codeOk)                  state_d = S_DISARM;
        else if (esc_q == ESC_LAST)  state_d = S_ESCALATED;
      end
      S_ESCALATED: begin
        if (codeOk)                  state_d = S_DISARM;
      end
      S_DISARM: begin
        if (!alarm_in && (state_in == 2'b00)) begin
          state_d = S_IDLE;
          esc_d   = '0;
          tries_d = '0;
          div_d   = '0;
          phase_d = 1'b0;
        end
      end
      S_LOCKOUT: begin
        if (lock_q == LOCK_LAST) begin
          state_d = S_ESCALATED;
          tries_d = '0;
        end else begin
          lock_d = lock_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (checking) begin
      if (codeOk) begin
        tries_d = '0;
      end else if (codeBad) begin
        tries_d = tries_q + 1'b1;
        if (tries_q == TRY_LAST) state_d = S_LOCKOUT;
      end
    end

    if ((state_d == S_SOUNDING) && (state_q != S_SOUNDING)) begin
      esc_d   = '0;
      div_d   = '0;
      phase_d = 1'b1;
    end
    if ((state_d == S_LOCKOUT) && (state_q != S_LOCKOUT)) begin
      lock_d = '0;
    end
  end

  // State, counters and outputs registered together so outputs track the new state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      esc_q      <= '0;
      lock_q     <= '0;
      div_q      <= '0;
      phase_q    <= 1'b0;
      tries_q    <= '0;
      siren      <= 1'b0;
      strobe     <= 1'b0;
      escalate   <= 1'b0;
      disarm_req <= 1'b0;
      lockout    <= 1'b0;
      resp_state <= 3'd0;
    end else begin
      state_q    <= state_d;
      esc_q      <= esc_d;
      lock_q     <= lock_d;
      div_q      <= div_d;
      phase_q    <= phase_d;
      tries_q    <= tries_d;
      resp_state <= state_d;
      siren      <= (state_d == S_SOUNDING) ? phase_d :
                    ((state_d == S_ESCALATED) || (state_d == S_LOCKOUT));
      strobe     <= (state_d == S_WARN) || (state_d == S_SOUNDING) ||
                    (state_d == S_ESCALATED) || (state_d == S_LOCKOUT);
      escalate   <= (state_d == S_ESCALATED) || (state_d == S_LOCKOUT);
      disarm_req <= (state_d == S_DISARM);
      lockout    <= (state_d == S_LOCKOUT);
    end
  end

`ifdef ALARM_RESPONDER_AUDIT_EN
  logic [7:0] badCnt_q;

  // Saturating audit of wrong codes; survives DISARM, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      badCnt_q <= 8'd0;
    end else if (checking && codeBad && (badCnt_q != 8'hFF)) begin
      badCnt_q <= badCnt_q + 8'd1;
    end
  end

  assign bad_code_count = badCnt_q;
`else
  assign bad_code_count = 8'd0;
`endif

endmodule

// File: tb/tb_alarm_responder.sv
// tb_alarm_responder: directed scenarios plus randomized traffic, each cycle
// compared against a behavioural model of the responder.
module tb_alarm_responder;

  localparam int ESC_CYCLES  = 16;
  localparam int SIREN_DIV   = 4;
  localparam int MAX_TRIES   = 3;
  localparam int LOCK_CYCLES = 32;
  localparam logic [3:0] GOOD = 4'hA;
  localparam logic [3:0] BAD  = 4'h3;
`ifdef ALARM_RESPONDER_AUDIT_EN
  localparam int AUDIT_ON = 1;
`else
  localparam int AUDIT_ON = 0;
`endif

  logic       clk;
  logic       rst;
  logic       alarmIn;
  logic [1:0] stateIn;
  logic [3:0] codeIn;
  logic       codeValid;
  logic       siren, strobe, escalate, disarm_req, lockout;
  logic [2:0] resp_state;
  logic [7:0] bad_code_count;
  logic [15:0] outVec;

  int checks = 0;
  int failures = 0;

  // Reference model state: plain integers, SOUNDING time measured from entry.
  int mSt, mT, mLock, mTries, mAudit;

  alarm_responder dut (
    .clk            (clk),
    .rst            (rst),
    .alarm_in       (alarmIn),
    .state_in       (stateIn),
    .code_in        (codeIn),
    .code_valid     (codeValid),
    .siren          (siren),
    .strobe         (strobe),
    .escalate       (escalate),
    .disarm_req     (disarm_req),
    .lockout        (lockout),
    .resp_state     (resp_state),
    .bad_code_count (bad_code_count)
  );

  assign outVec = {resp_state, siren, strobe, escalate, disarm_req, lockout, bad_code_count};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    mSt = 0; mT = 0; mLock = 0; mTries = 0; mAudit = 0;
  endtask

  task automatic modelStep();
    bit ok, bad, chk;
    int nxt;
    ok  = codeValid && (codeIn == GOOD);
    bad = codeValid && (codeIn != GOOD);
    chk = (mSt == 1) || (mSt == 2) || (mSt == 3);
    nxt = mSt;
    case (mSt)
      0: if (alarmIn) nxt = 2; else if (stateIn == 2'b10) nxt = 1;
      1: if (alarmIn) nxt = 2; else if (stateIn < 2) nxt = 0; else if (ok) nxt = 4;
      2: if (ok) nxt = 4; else if (mT == ESC_CYCLES - 1) nxt = 3;
      3: if (ok) nxt = 4;
      4: if (!alarmIn && stateIn == 2'b00) begin nxt = 0; mTries = 0; end
      5: if (mLock == LOCK_CYCLES - 1) begin nxt = 3; mTries = 0; end
      default: nxt = 0;
    endcase
    if (chk) begin
      if (ok) mTries = 0;
      else if (bad) begin
        mTries++;
        if (mAudit < 255) mAudit++;
        if (mTries == MAX_TRIES) nxt = 5;
      end
    end
    if (nxt == 2) mT = (mSt == 2) ? mT + 1 : 0;
    if (nxt == 5) mLock = (mSt == 5) ? mLock + 1 : 0;
    mSt = nxt;
  endtask

  function automatic logic [15:0] modelVec();
    logic sir, str, esc, dis, lck;
    logic [7:0] aud;
    sir = (mSt == 2) ? (((mT / SIREN_DIV) % 2) == 0) : ((mSt == 3) || (mSt == 5));
    str = (mSt == 1) || (mSt == 2) || (mSt == 3) || (mSt == 5);
    esc = (mSt == 3) || (mSt == 5);
    dis = (mSt == 4);
    lck = (mSt == 5);
    aud = (AUDIT_ON != 0) ? 8'(mAudit) : 8'd0;
    return {3'(mSt), sir, str, esc, dis, lck, aud};
  endfunction

  task automatic applyStimulus(input logic a, input logic [1:0] s, input logic [3:0] c, input logic v);
    alarmIn = a; stateIn = s; codeIn = c; codeValid = v;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("cycle", 32'(outVec), 32'(modelVec()));
  endtask

  task automatic doReset();
    rst = 1'b1;
    alarmIn = 1'b0; stateIn = 2'b00; codeIn = 4'h0; codeValid = 1'b0;
    #2;
    modelReset();
    checkOutput("reset_outputs", 32'(outVec), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic midCycleReset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    checkOutput(tag, 32'(outVec), 32'd0);
    modelReset();
    alarmIn = 1'b0; stateIn = 2'b00; codeIn = 4'h0; codeValid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] sirenBits;
    logic        escSeen;
    int          n;
    int          given;
    int          cyc;
    logic        ra, rv;
    logic [1:0]  rs;
    logic [3:0]  rc;

    rst = 1'b0; alarmIn = 1'b0; stateIn = 2'b00; codeIn = 4'h0; codeValid = 1'b0;
    #1;
    doReset();

    // Warning enter and exit
    applyStimulus(1'b0, 2'b10, 4'h0, 1'b0);
    checkOutput("warn_state", 32'(resp_state), 32'd1);
    checkOutput("warn_strobe", 32'(strobe), 32'd1);
    applyStimulus(1'b0, 2'b01, 4'h0, 1'b0);
    checkOutput("warn_exit_state", 32'(resp_state), 32'd0);
    checkOutput("warn_exit_strobe", 32'(strobe), 32'd0);

    // Siren pattern and escalation timing
    applyStimulus(1'b1, 2'b11, 4'h0, 1'b0);
    checkOutput("sound_state", 32'(resp_state), 32'd2);
    sirenBits = '0;
    sirenBits[15] = siren;
    escSeen = escalate;
    for (int i = 1; i < 16; i++) begin
      applyStimulus(1'b1, 2'b11, 4'h0, 1'b0);
      sirenBits[15 - i] = siren;
      escSeen = escSeen | escalate;
    end
    checkOutput("siren_pattern", 32'(sirenBits), 32'h0000F0F0);
    checkOutput("esc_early", 32'(escSeen), 32'd0);
    applyStimulus(1'b1, 2'b11, 4'h0, 1'b0);
    checkOutput("esc_at_16", 32'(escalate), 32'd1);
    checkOutput("esc_state", 32'(resp_state), 32'd3);

    // Disarm from SOUNDING and hold until the security FSM is OFF
    doReset();
    applyStimulus(1'b1, 2'b11, 4'h0, 1'b0);
    applyStimulus(1'b1, 2'b11, GOOD, 1'b1);
    checkOutput("disarm_req", 32'(disarm_req), 32'd1);
    checkOutput("disarm_siren", 32'(siren), 32'd0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'b11, 4'h0, 1'b0);
    checkOutput("disarm_hold", 32'(resp_state), 32'd4);
    applyStimulus(1'b0, 2'b00, 4'h0, 1'b0);
    checkOutput("disarm_exit_state", 32'(resp_state), 32'd0);
    checkOutput("disarm_exit_req", 32'(disarm_req), 32'd0);

    // Lockout from WARN; correct code ignored; timed exit to ESCALATED
    doReset();
    applyStimulus(1'b0, 2'b10, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'b10, BAD, 1'b1);
    checkOutput("lock_flag", 32'(lockout), 32'd1);
    checkOutput("lock_state", 32'(resp_state), 32'd5);
    applyStimulus(1'b0, 2'b10, GOOD, 1'b1);
    checkOutput("lock_ignore_code", 32'(resp_state), 32'd5);
    n = 1;
    while (resp_state == 3'd5 && n < 100) begin
      applyStimulus(1'b0, 2'b10, 4'h0, 1'b0);
      n++;
    end
    checkOutput("lock_duration", 32'(n), 32'(LOCK_CYCLES));
    checkOutput("lock_exit_state", 32'(resp_state), 32'd3);
    checkOutput("lock_exit_flag", 32'(lockout), 32'd0);

    // Asynchronous reset while ESCALATED
    midCycleReset("async_rst_outputs");

    // Correct code on the escalation cycle wins
    applyStimulus(1'b1, 2'b11, 4'h0, 1'b0);
    escSeen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b1, 2'b11, 4'h0, 1'b0);
      escSeen = escSeen | escalate;
    end
    applyStimulus(1'b1, 2'b11, GOOD, 1'b1);
    escSeen = escSeen | escalate;
    checkOutput("simul_disarm_state", 32'(resp_state), 32'd4);
    checkOutput("simul_no_escalate", 32'(escSeen), 32'd0);

    // Third wrong code on the escalation cycle locks out
    doReset();
    applyStimulus(1'b1, 2'b11, 4'h0, 1'b0);
    applyStimulus(1'b1, 2'b11, BAD, 1'b1);
    applyStimulus(1'b1, 2'b11, BAD, 1'b1);
    for (int i = 0; i < 13; i++) applyStimulus(1'b1, 2'b11, 4'h0, 1'b0);
    applyStimulus(1'b1, 2'b11, BAD, 1'b1);
    checkOutput("simul_lock_state", 32'(resp_state), 32'd5);

    // 300 wrong codes across repeated lockouts
    doReset();
    applyStimulus(1'b0, 2'b10, 4'h0, 1'b0);
    given = 0;
    cyc = 0;
    while (given < 300 && cyc < 8000) begin
      if (mSt == 1 || mSt == 2 || mSt == 3) begin
        applyStimulus(1'b0, 2'b10, BAD, 1'b1);
        given++;
      end else begin
        applyStimulus(1'b0, 2'b10, 4'h0, 1'b0);
      end
      cyc++;
    end
    checkOutput("audit_given", 32'(given), 32'd300);
    checkOutput("audit_count", 32'(bad_code_count), (AUDIT_ON != 0) ? 32'd255 : 32'd0);

    // Randomized traffic with occasional mid-cycle resets
    doReset();
    for (int i = 0; i < 3000; i++) begin
      ra = ($urandom_range(0, 9) == 0);
      rs = 2'($urandom_range(0, 3));
      rv = ($urandom_range(0, 2) == 0);
      rc = ($urandom_range(0, 7) == 0) ? GOOD : 4'($urandom_range(0, 15));
      applyStimulus(ra, rs, rc, rv);
      if ($urandom_range(0, 299) == 0) midCycleReset("rand_async_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
